// File: rtl/pep_ks_common_param_pkg.sv
// ----------------------------------------------------------------------------
// pep_ks_common_param_pkg
// Shared parameters and types for the KS BLWE RAM write side.
//   - Geometry of a BLWE in the BLRAM (LBY lanes, BLWE_K coefficients,
//     KS_DECOMP_W bits per decomposed coefficient, TOTAL_PBS_NB slots).
//   - LINE_PER_PID_DEF: default number of lines per BLWE.
//   - ks_blwe_wr_state_e: write FSM states.
//   - Helpers building the lane masks applied to the last line of a BLWE.
// ----------------------------------------------------------------------------
package pep_ks_common_param_pkg;

  localparam int LBY          = 4;
  localparam int BLWE_K       = 10;
  localparam int KS_DECOMP_W  = 8;
  localparam int TOTAL_PBS_NB = 8;
  localparam int PID_W        = 3;

  // Lines needed to hold one BLWE, rounded up to a full line.
  localparam int LINE_PER_PID_DEF = (BLWE_K + LBY - 1) / LBY;

  typedef enum logic [1:0] {
    KS_BLWE_WR_IDLE  = 2'd0,
    KS_BLWE_WR_WAIT  = 2'd1,
    KS_BLWE_WR_WRITE = 2'd2
  } ks_blwe_wr_state_e;

  // Lanes of the last line that carry a real coefficient.
  function automatic logic [LBY-1:0] last_line_used_mask(input int lpp);
    logic [LBY-1:0] m;
    m = {LBY{1'b0}};
    for (int l = 0; l < LBY; l++) begin
      m[l] = (((lpp - 1) * LBY + l) < BLWE_K);
    end
    return m;
  endfunction

  // Per-bit expansion of a lane mask over a full coefficient line.
  function automatic logic [LBY*KS_DECOMP_W-1:0] lane_to_data_mask(input logic [LBY-1:0] lm);
    logic [LBY*KS_DECOMP_W-1:0] m;
    m = {(LBY*KS_DECOMP_W){1'b0}};
    for (int l = 0; l < LBY; l++) begin
      m[l*KS_DECOMP_W +: KS_DECOMP_W] = {KS_DECOMP_W{lm[l]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/pep_ks_blwe_slot_track.sv
// ----------------------------------------------------------------------------
// pep_ks_blwe_slot_track
// Per-PID occupancy bitmap of the BLRAM slots.
//   clk, a_rst          : clock, asynchronous active-high reset
//   set_en / set_pid    : mark a slot busy (its last line is being written)
//   clr_en / clr_pid    : release a slot (KS pipeline done with it)
//   query_pid           : slot the write FSM is waiting on
//   query_busy          : busy state of query_pid with this cycle's release
//                         already applied, so a release can unblock the
//                         writer in the same cycle
//   slot_busy           : registered occupancy bitmap
// A set and a clear on the same slot in one cycle leave the slot busy.
// ----------------------------------------------------------------------------
module pep_ks_blwe_slot_track
  import pep_ks_common_param_pkg::*;
(
  input  logic                    clk,
  input  logic                    a_rst,
  input  logic                    set_en,
  input  logic [PID_W-1:0]        set_pid,
  input  logic                    clr_en,
  input  logic [PID_W-1:0]        clr_pid,
  input  logic [PID_W-1:0]        query_pid,
  output logic                    query_busy,
  output logic [TOTAL_PBS_NB-1:0] slot_busy
);

  logic [TOTAL_PBS_NB-1:0] busy_q;
  logic [TOTAL_PBS_NB-1:0] busy_d;

  // Next bitmap: clear first, then set, so the set has priority.
  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_pid] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (set_en) begin
      busy_d[set_pid] = 1'b1;
    end else begin
      busy_d[set_pid] = busy_d[set_pid];
    end
  end

  // Bypassed query: a release of the queried slot in this cycle reads as free.
  always_comb begin
    query_busy = busy_q[query_pid] & ~(clr_en & (clr_pid == query_pid));
  end

  // Occupancy register.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      busy_q <= {TOTAL_PBS_NB{1'b0}};
    end else begin
      busy_q <= busy_d;
    end
  end

  assign slot_busy = busy_q;

endmodule

// File: rtl/pep_ks_blwe_ram_wr.sv
// ----------------------------------------------------------------------------
// pep_ks_blwe_ram_wr
// Write side of the KS BLWE RAM. Takes a command naming a PBS slot, waits
// for that slot to be free, then writes LINE_PER_PID coefficient lines into
// the LBY BLRAM lanes at pid*LINE_PER_PID + line. Raises blwe_avail with the
// last write and marks the slot busy until slot_free releases it.
//
// Ports:
//   clk, a_rst                    : clock, asynchronous active-high reset
//   wcmd_pid, wcmd_vld, wcmd_rdy  : slot command handshake (rdy only in IDLE)
//   in_data, in_vld, in_rdy       : coefficient line handshake
//   slot_free, slot_free_pid      : slot release pulse
//   wr_blram_en/add/data          : registered BLRAM write port, per lane
//   blwe_avail, blwe_avail_pid    : registered completion pulse
//   slot_busy                     : occupancy bitmap
//
// Build option PEP_KS_BLWE_WR_ZERO_PAD_EN: when defined, lanes of the last
// line beyond BLWE_K are written with zero; otherwise they are not written.
// ----------------------------------------------------------------------------
module pep_ks_blwe_ram_wr
  import pep_ks_common_param_pkg::*;
#(
  parameter  int LINE_PER_PID   = LINE_PER_PID_DEF,
  parameter  int BLWE_RAM_DEPTH = LINE_PER_PID * TOTAL_PBS_NB,
  localparam int BLWE_RAM_ADD_W = (BLWE_RAM_DEPTH > 1) ? $clog2(BLWE_RAM_DEPTH) : 1
)(
  input  logic                            clk,
  input  logic                            a_rst,
  input  logic [PID_W-1:0]                wcmd_pid,
  input  logic                            wcmd_vld,
  output logic                            wcmd_rdy,
  input  logic [LBY*KS_DECOMP_W-1:0]      in_data,
  input  logic                            in_vld,
  output logic                            in_rdy,
  input  logic                            slot_free,
  input  logic [PID_W-1:0]                slot_free_pid,
  output logic [LBY-1:0]                  wr_blram_en,
  output logic [LBY*BLWE_RAM_ADD_W-1:0]   wr_blram_add,
  output logic [LBY*KS_DECOMP_W-1:0]      wr_blram_data,
  output logic                            blwe_avail,
  output logic [PID_W-1:0]                blwe_avail_pid,
  output logic [TOTAL_PBS_NB-1:0]         slot_busy
);

  localparam int LINE_W = (LINE_PER_PID > 1) ? $clog2(LINE_PER_PID) : 1;
  localparam logic [LINE_W-1:0] LAST_LINE = LINE_W'(LINE_PER_PID - 1);
  localparam logic [LBY-1:0] LAST_LANE_MASK = last_line_used_mask(LINE_PER_PID);

  ks_blwe_wr_state_e state_q, state_d;
  logic [PID_W-1:0]          pid_q, pid_d;
  logic [LINE_W-1:0]         line_q, line_d;
  logic [BLWE_RAM_ADD_W-1:0] add_q, add_d;
  logic [BLWE_RAM_ADD_W-1:0] pid_base;
  logic [BLWE_RAM_ADD_W-1:0] base_acc;
  logic                      query_busy;
  logic                      line_acc;
  logic                      last_acc;

  logic [LBY-1:0]                wr_en_q, wr_en_d;
  logic [LBY*BLWE_RAM_ADD_W-1:0] wr_add_q, wr_add_d;
  logic [LBY*KS_DECOMP_W-1:0]    wr_data_q, wr_data_d;
  logic                          avail_q, avail_d;
  logic [PID_W-1:0]              avail_pid_q, avail_pid_d;

  // Slot base address: select among running multiples of LINE_PER_PID.
  always_comb begin
    pid_base = {BLWE_RAM_ADD_W{1'b0}};
    base_acc = {BLWE_RAM_ADD_W{1'b0}};
    for (int i = 0; i < TOTAL_PBS_NB; i++) begin
      if (int'(wcmd_pid) == i) begin
        pid_base = base_acc;
      end else begin
        pid_base = pid_base;
      end
      base_acc = base_acc + BLWE_RAM_ADD_W'(LINE_PER_PID);
    end
  end

  // Write FSM: next state, handshakes and line/address counters.
  // WAIT resolves in the cycle it is entered: once the slot reads free
  // (release bypass included) the first line can be taken right away.
  always_comb begin
    state_d  = state_q;
    pid_d    = pid_q;
    line_d   = line_q;
    add_d    = add_q;
    wcmd_rdy = 1'b0;
    in_rdy   = 1'b0;
    case (state_q)
      KS_BLWE_WR_IDLE: begin
        wcmd_rdy = 1'b1;
        if (wcmd_vld) begin
          pid_d   = wcmd_pid;
          line_d  = {LINE_W{1'b0}};
          add_d   = pid_base;
          state_d = KS_BLWE_WR_WAIT;
        end else begin
          state_d = KS_BLWE_WR_IDLE;
        end
      end
      KS_BLWE_WR_WAIT: begin
        in_rdy = ~query_busy;
        if (!query_busy) begin
          state_d = KS_BLWE_WR_WRITE;
        end else begin
          state_d = KS_BLWE_WR_WAIT;
        end
      end
      KS_BLWE_WR_WRITE: begin
        in_rdy = 1'b1;
      end
      default: begin
        state_d = KS_BLWE_WR_IDLE;
      end
    endcase
    line_acc = in_rdy & in_vld;
    last_acc = line_acc & (line_q == LAST_LINE);
    if (line_acc) begin
      line_d = line_q + 1'b1;
      add_d  = add_q + 1'b1;
      if (line_q == LAST_LINE) begin
        state_d = KS_BLWE_WR_IDLE;
      end else begin
        state_d = KS_BLWE_WR_WRITE;
      end
    end else begin
      line_d = line_d;
    end
  end

  // Write port and completion pulse, one register stage after acceptance.
  always_comb begin
    wr_en_d     = {LBY{1'b0}};
    wr_add_d    = wr_add_q;
    wr_data_d   = wr_data_q;
    avail_d     = 1'b0;
    avail_pid_d = avail_pid_q;
    if (line_acc) begin
      wr_en_d   = {LBY{1'b1}};
      wr_add_d  = {LBY{add_q}};
      wr_data_d = in_data;
      if (last_acc) begin
        avail_d     = 1'b1;
        avail_pid_d = pid_q;
`ifdef PEP_KS_BLWE_WR_ZERO_PAD_EN
        wr_data_d   = in_data & lane_to_data_mask(LAST_LANE_MASK);
`else
        wr_en_d     = LAST_LANE_MASK;
`endif
      end else begin
        avail_d = 1'b0;
      end
    end else begin
      wr_en_d = {LBY{1'b0}};
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= KS_BLWE_WR_IDLE;
      pid_q       <= {PID_W{1'b0}};
      line_q      <= {LINE_W{1'b0}};
      add_q       <= {BLWE_RAM_ADD_W{1'b0}};
      wr_en_q     <= {LBY{1'b0}};
      wr_add_q    <= {(LBY*BLWE_RAM_ADD_W){1'b0}};
      wr_data_q   <= {(LBY*KS_DECOMP_W){1'b0}};
      avail_q     <= 1'b0;
      avail_pid_q <= {PID_W{1'b0}};
    end else begin
      state_q     <= state_d;
      pid_q       <= pid_d;
      line_q      <= line_d;
      add_q       <= add_d;
      wr_en_q     <= wr_en_d;
      wr_add_q    <= wr_add_d;
      wr_data_q   <= wr_data_d;
      avail_q     <= avail_d;
      avail_pid_q <= avail_pid_d;
    end
  end

  pep_ks_blwe_slot_track u_slot_track (
    .clk        (clk),
    .a_rst      (a_rst),
    .set_en     (last_acc),
    .set_pid    (pid_q),
    .clr_en     (slot_free),
    .clr_pid    (slot_free_pid),
    .query_pid  (pid_q),
    .query_busy (query_busy),
    .slot_busy  (slot_busy)
  );

  assign wr_blram_en    = wr_en_q;
  assign wr_blram_add   = wr_add_q;
  assign wr_blram_data  = wr_data_q;
  assign blwe_avail     = avail_q;
  assign blwe_avail_pid = avail_pid_q;

endmodule
